apu_cmd_uart_tx: RTL

Host-side command serializer for the sound core's UART register-write link. It accepts APU register writes (6-bit register index, 8-bit value) through a valid/ready port and buffers them in a small FIFO. Each write is sent on `tx` as two 8N1 frames: a data frame, then an address frame. The wire format is the one the on-chip UART receiver decodes. The block is used in host/controller builds and as a synthesizable stimulus source in benches.

---
 rtl/apu_cmd_uart_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/apu_cmd_uart_tx.sv
// APU register-write serializer: {addr,data} commands -> two 8N1 frames (data, then address) on tx.
// Latency: write into idle empty block starts the frame (tx falls) one edge after acceptance.
// Backpressure: wr_ready = !full; optional APU_TX_STOP2_EN adds a second stop bit.

module apu_cmd_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign in_rdy  = (count != (AW+1)'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  // A full FIFO refuses a push even when a pop happens the same cycle.
  assign push    = in_vld && in_rdy;
  assign pop     = out_rdy && out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end
endmodule

module apu_cmd_uart_tx #(
  parameter int CLKS_PER_BIT = 186,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    addr_byte;
  logic          byte_sel;

  logic          fifo_vld;
  logic          fifo_pop;
  logic [13:0]   fifo_dat;
  logic [7:0]    data_byte_nxt;
  logic [7:0]    addr_byte_nxt;
  logic          baud_end;
  logic          stop_end;

  apu_cmd_fifo #(.W(14), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (wr_valid),
    .in_rdy  (wr_ready),
    .in_dat  ({wr_addr, wr_data}),
    .out_vld (fifo_vld),
    .out_rdy (fifo_pop),
    .out_dat (fifo_dat)
  );

  // data[7] travels in the address frame so both frames carry a type flag in bit 7.
  assign data_byte_nxt = {1'b0, fifo_dat[6:0]};
  assign addr_byte_nxt = {1'b1, fifo_dat[13:8], fifo_dat[7]};
  assign baud_end      = (baud_cnt == BAUD_LAST);

`ifdef APU_TX_STOP2_EN
  logic stop_ph;
  assign stop_end = baud_end && stop_ph;
`else
  assign stop_end = baud_end;
`endif

  assign fifo_pop = fifo_vld &&
                    ((state == IDLE) || ((state == STOP) && stop_end && byte_sel));
  assign busy     = (state != IDLE) || fifo_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      addr_byte <= '0;
      byte_sel  <= 1'b0;
      tx        <= 1'b1;
`ifdef APU_TX_STOP2_EN
      stop_ph   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (fifo_vld) begin
            shreg     <= data_byte_nxt;
            addr_byte <= addr_byte_nxt;
            byte_sel  <= 1'b0;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
`ifdef APU_TX_STOP2_EN
            stop_ph  <= !stop_ph;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
          // Next frame starts straight from STOP so the line never idles between frames.
          if (stop_end) begin
            if (!byte_sel) begin
              shreg    <= addr_byte;
              byte_sel <= 1'b1;
              tx       <= 1'b0;
              state    <= START;
            end else if (fifo_vld) begin
              shreg     <= data_byte_nxt;
              addr_byte <= addr_byte_nxt;
              byte_sel  <= 1'b0;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
